// File: rtl/sv32_pkg.sv
// sv32_pkg: shared Sv32 PTE layout, walker widths and FSM encoding
package sv32_pkg;
    localparam int VPN_W     = 20;
    localparam int PTE_W     = 64;
    localparam int PA_W      = 34;
    localparam int PPN_W     = 22;
    localparam int PG_OFFSET = 12;
    localparam int PTE_V     = 0;
    localparam int PTE_R     = 1;
    localparam int PTE_W_BIT = 2;
    localparam int PTE_X     = 3;
    localparam int PTE_U     = 4;
    localparam int PTE_G     = 5;
    localparam int PTE_A     = 6;
    localparam int PTE_D     = 7;
    localparam int PPN0_LSB  = 10;
    localparam int PPN0_MSB  = 19;
    localparam int PPN1_LSB  = 20;
    localparam int PPN1_MSB  = 31;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } sv32_pte_t;

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, FAULT, DRAIN
    } ptw_state_e;
endpackage

// File: rtl/sv32_pte_check.sv
// sv32_pte_check: classifies one PTE as leaf/pointer and flags faults
module sv32_pte_check
    import sv32_pkg::*;
(
    input  logic [31:0]      pte_i,
    input  logic             level_i,
    input  logic             store_i,
    output logic             is_leaf_o,
    output logic             fault_o,
    output logic [PPN_W-1:0] next_ppn_o
);
    sv32_pte_t p;
    logic      unused_bits;
    assign p           = sv32_pte_t'(pte_i);
    assign unused_bits = ^{p.rsw, p.g, p.u};
    assign is_leaf_o   = p.r | p.x;
    assign next_ppn_o  = {p.ppn1, p.ppn0};
    // A/D are never updated in hardware, so a clear A (or clear D on a store) faults
    always_comb fault_o = ~p.v | (~p.r & p.w) |
        (is_leaf_o ? (level_i & |p.ppn0) | ~p.a | (store_i & ~p.d) : ~level_i);
endmodule

// File: rtl/sv32_ptw.sv
// sv32_ptw: Sv32 two-level page-table walker that fills the TLB on a miss
module sv32_ptw
    import sv32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VPN_W-1:0] req_vpn,
    input  logic             req_store,
    input  logic [PPN_W-1:0] satp_ppn,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [PA_W-1:0]  mem_addr,
    input  logic             mem_rsp_valid,
    input  logic             mem_rsp_err,
    input  logic [31:0]      mem_rdata,
    output logic             tlb_we,
    output logic [VPN_W-1:0] tlb_vpn,
    output logic             tlb_spage,
    output logic [PTE_W-1:0] tlb_pte,
    output logic             resp_valid,
    output logic             resp_fault,
    input  logic             flush_req
);
    ptw_state_e       state_q;
    logic [VPN_W-1:0] vpn_q;
    logic [PA_W-1:0]  mem_addr_q;
    logic [31:0]      pte_q;
    logic             store_q, req_ready_q, mem_req_valid_q, tlb_we_q, tlb_spage_q;
    logic             resp_valid_q, resp_fault_q;
    logic             is_leaf, chk_fault;
    logic [PPN_W-1:0] next_ppn;

    sv32_pte_check u_chk (
        .pte_i      (mem_rdata),
        .level_i    (state_q == L1_WAIT),
        .store_i    (store_q),
        .is_leaf_o  (is_leaf),
        .fault_o    (chk_fault),
        .next_ppn_o (next_ppn)
    );

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign tlb_we        = tlb_we_q & ~flush_req;
    assign tlb_vpn       = vpn_q;
    assign tlb_spage     = tlb_spage_q;
    assign tlb_pte       = {{(PTE_W-32){1'b0}}, pte_q};
    assign resp_valid    = resp_valid_q;
    assign resp_fault    = resp_fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            vpn_q           <= '0;
            store_q         <= 1'b0;
            pte_q           <= '0;
            mem_addr_q      <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            tlb_we_q        <= 1'b0;
            tlb_spage_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_fault_q    <= 1'b0;
        end else begin
            tlb_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            unique case (state_q)
                IDLE: if (req_valid) begin
                    state_q         <= L1_REQ;
                    vpn_q           <= req_vpn;
                    store_q         <= req_store;
                    req_ready_q     <= 1'b0;
                    mem_req_valid_q <= 1'b1;
                    mem_addr_q      <= {satp_ppn, {PG_OFFSET{1'b0}}} + PA_W'({req_vpn[VPN_W-1:10], 2'b00});
                end
                L1_REQ, L0_REQ: if (flush_req) begin
                    mem_req_valid_q <= 1'b0;
                    state_q         <= mem_req_ready ? DRAIN : IDLE;
                    req_ready_q     <= ~mem_req_ready;
                end else if (mem_req_ready) begin
                    mem_req_valid_q <= 1'b0;
                    state_q         <= state_q == L1_REQ ? L1_WAIT : L0_WAIT;
                end
                L1_WAIT, L0_WAIT: if (mem_rsp_valid) begin
                    // a flush landing with the response has nothing left to drain
                    if (flush_req) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end else if (mem_rsp_err | chk_fault) begin
                        state_q      <= FAULT;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                    end else if (is_leaf) begin
                        state_q      <= FILL;
                        tlb_we_q     <= 1'b1;
                        resp_valid_q <= 1'b1;
                        tlb_spage_q  <= state_q == L1_WAIT;
                        pte_q        <= mem_rdata;
                    end else begin
                        state_q         <= L0_REQ;
                        mem_req_valid_q <= 1'b1;
                        mem_addr_q      <= {next_ppn, {PG_OFFSET{1'b0}}} + PA_W'({vpn_q[9:0], 2'b00});
                    end
                end else if (flush_req) begin
                    state_q <= DRAIN;
                end
                FILL, FAULT: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                DRAIN: if (mem_rsp_valid) begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sv32_ptw.md
Name: sv32_ptw

Overview:
- Hardware page-table walker that services TLB misses for Sv32 translation.
- Accepts a miss request (VPN, access type) from the MMU, reads level-1 and, if needed, level-0 PTEs over a single-outstanding memory port, and checks them.
- On success it writes the leaf PTE into the TLB (cs/we/spage/pte_in side); on failure it reports a page fault.
- Sits directly upstream of the TLB fill port and between the MMU and the data-side bus.

Parameters:
- VPN_W, 20, virtual page number width (vpn1 = [19:10], vpn0 = [9:0])
- PTE_W, 64, TLB PTE storage width; the 32-bit PTE is zero-extended
- PA_W, 34, physical address width
- PPN_W, 22, satp root PPN width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- req_valid  in  1  miss request
- req_ready  out  1  walker idle, request accepted when valid&ready
- req_vpn  in  VPN_W  missing VPN
- req_store  in  1  access is a store (D-bit check)
- satp_ppn  in  PPN_W  root page-table PPN, sampled at accept
- mem_req_valid  out  1  PTE read request
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  PA_W  PTE physical address
- mem_rsp_valid  in  1  read data returned
- mem_rsp_err  in  1  bus error with response
- mem_rdata  in  32  PTE word
- tlb_we  out  1  one-cycle TLB write strobe (drives TLB cs and we)
- tlb_vpn  out  VPN_W  VPN for the TLB write
- tlb_spage  out  1  leaf found at level 1 (4 MiB superpage)
- tlb_pte  out  PTE_W  leaf PTE, zero-extended
- resp_valid  out  1  one-cycle completion pulse
- resp_fault  out  1  valid with resp_valid: page or access fault
- flush_req  in  1  sfence/TLB flush, aborts the walk

Behaviour:
- Reset (rst high at a clk edge) forces state IDLE and zeroes every output, except req_ready, which is 1 in IDLE.
- Reset mid-walk abandons the walk with no TLB write and no resp pulse. An in-flight mem response arriving after reset is ignored because the state is IDLE.
- FSM states: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, FILL, FAULT, DRAIN.
- IDLE: req_ready=1. On valid&ready, latch vpn, store and satp_ppn, then go to L1_REQ.
- L1_REQ: mem_req_valid=1, mem_addr = {satp_ppn,12'b0} + {vpn1,2'b0}, truncated to PA_W. Hold the request until ready, then go to L1_WAIT.
- L1_WAIT: wait for mem_rsp_valid, then evaluate the PTE:
  - err, or V=0, or (R=0 & W=1): go to FAULT.
  - leaf (R|X) with PTE[19:10] != 0 (misaligned superpage): go to FAULT.
  - leaf that is otherwise good: go to FILL with spage=1.
  - non-leaf: go to L0_REQ with mem_addr = {PTE[31:10],12'b0} + {vpn0,2'b0}.
- L0_WAIT: same checks as L1_WAIT. A non-leaf PTE is a FAULT. A good leaf goes to FILL with spage=0.
- Leaf checks applied in both WAIT states: A=0 is a FAULT (no hardware A/D update); req_store & D=0 is a FAULT.
- FILL: one cycle with tlb_we=1, tlb_vpn=latched vpn, tlb_spage, tlb_pte={zeros,PTE}, resp_valid=1, resp_fault=0. Then go to IDLE.
- FAULT: one cycle with resp_valid=1, resp_fault=1, tlb_we=0. Then go to IDLE.
- Latency with zero-wait memory and a 1-cycle response:
  - superpage: accept to resp_valid = 3 cycles.
  - 4 KiB page: 5 cycles.
- The memory port allows a single outstanding read only. mem_addr and mem_req_valid stay stable while waiting for ready.
- flush_req:
  - in IDLE, FILL or FAULT: no effect on the current cycle's outputs. A FILL coinciding with a flush is suppressed (tlb_we=0, resp_valid=1, resp_fault=0), so the TLB is never refilled during a flush.
  - in *_REQ before the handshake: drop the request and go to IDLE. No resp pulse.
  - in *_WAIT, or *_REQ with a simultaneous handshake: go to DRAIN.
- DRAIN: req_ready=0. Consume exactly one mem_rsp_valid, then go to IDLE. No resp pulse and no TLB write.
- req_valid while busy is ignored (req_ready=0). The MMU holds it.
- mem_rsp_valid in IDLE is ignored.

Decomposition:
- Shared package sv32_pkg holds:
  - PTE bit-index constants (V,R,W,X,U,G,A,D and the PPN1/PPN0 ranges).
  - typedef sv32_pte_t (packed struct).
  - a ptw_state_e enum.
  - the page-offset constant 12.
- One natural sub-module: sv32_pte_check, combinational. Inputs are pte, level and store. Outputs are is_leaf, fault and next_ppn. It is instantiated once and used in both WAIT states.

Test Plan:
- Superpage hit path: satp_ppn=0x00100, vpn=0x40123, L1 PTE=0x200000CF → mem_addr 0x100400. Then tlb_we=1, tlb_spage=1, tlb_pte=0x200000CF, resp_fault=0, 3 cycles after accept.
- Two-level walk: L1 PTE=0x00080001 (pointer) → second read at 0x200000+0x123*4=0x20048C. L0 PTE=0x123450C7 → tlb_we=1, spage=0, tlb_vpn=0x40123.
- Faults, each giving resp_valid=1, resp_fault=1, tlb_we=0:
  - L1 PTE=0x00000000.
  - L1 PTE=0x20040CF (misaligned superpage).
  - store with leaf PTE=0x2000004F (D=0).
  - non-leaf PTE at L0.
- Bus error: mem_rsp_err=1 on the L0 response → fault pulse. A new request is accepted the next cycle.
- Flush in L0_WAIT: flush_req pulse, response arrives 4 cycles later → no tlb_we, no resp. req_ready returns to 1 the cycle after that response.
- Reset asserted in L1_WAIT, then a stray mem_rsp_valid arrives → all outputs 0, req_ready=1, no TLB write.
